// File: rtl/issue_scoreboard_pkg.sv
// pipeline_types: shared types and constants for the issue scoreboard.
//   sb_stall_t  - stall reason encoding driven on stall_reason
//   div_state_t - divider occupancy FSM states
//   SB_CNT_MAX  - saturation value of the per-register pending counters
`timescale 1ns/1ps
package pipeline_types;

  typedef enum logic [1:0] {
    SB_NONE     = 2'd0,
    SB_RAW      = 2'd1,
    SB_WAW_SAT  = 2'd2,
    SB_DIV_BUSY = 2'd3
  } sb_stall_t;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_DONE = 2'd2
  } div_state_t;

  localparam logic [1:0] SB_CNT_MAX = 2'd3;

endpackage

// File: rtl/issue_scoreboard_div_fsm.sv
// div_busy_fsm: divider occupancy tracker.
//   clk, rst (async, active-low)
//   start - a divide fires this cycle
//   flush - abandon any divide in flight
//   busy  - divider occupied, a new divide must wait
//   done  - one-cycle pulse when occupancy ends
//
// state    | meaning
// DIV_IDLE | divider free
// DIV_BUSY | divide in flight, down-counter running
// DIV_DONE | last occupancy cycle, done pulses, new divide may fire
`timescale 1ns/1ps
module div_busy_fsm
  import pipeline_types::*;
#(
  parameter int DIV_LATENCY = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic flush,
  output logic busy,
  output logic done
);

  // BUSY spans DIV_LATENCY-1 cycles and the counter exits at 0, hence the -2.
  localparam logic [4:0] LOAD_VAL = 5'(DIV_LATENCY - 2);

  div_state_t state, state_next;
  logic [4:0] cnt, cnt_next;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= DIV_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      DIV_IDLE: begin
        if (start) begin
          state_next = DIV_BUSY;
          cnt_next   = LOAD_VAL;
        end
      end
      DIV_BUSY: begin
        if (cnt == 5'd0) state_next = DIV_DONE;
        else             cnt_next   = cnt - 5'd1;
      end
      DIV_DONE: begin
        if (start) begin
          state_next = DIV_BUSY;
          cnt_next   = LOAD_VAL;
        end else begin
          state_next = DIV_IDLE;
        end
      end
      default: state_next = DIV_IDLE;
    endcase
    if (flush) begin
      state_next = DIV_IDLE;
      cnt_next   = '0;
    end
  end

  assign busy = (state == DIV_BUSY);
  assign done = (state == DIV_DONE);

endmodule

// File: rtl/issue_scoreboard.sv
// issue_scoreboard: dispatch-stage hazard controller for long-latency writes
// (loads, ll.w/sc.w, divides) and divider occupancy.
//   clk, rst (async, active-low)
//   issue_*         - instruction offered by dispatch this cycle
//   wb_valid/addr   - long-latency writeback this cycle
//   flush           - kill everything in flight
//   stall           - dispatch must hold; stall_reason says why
//   pending_vec     - registers with an outstanding long write
//   div_done        - divider occupancy end pulse
//   perf_*_cycles   - stall cycle counters, present only with
//                     SCOREBOARD_PERF_EN defined (tied to 0 otherwise)
`timescale 1ns/1ps
module issue_scoreboard
  import pipeline_types::*;
#(
  parameter int DIV_LATENCY = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        issue_valid,
  input  logic        issue_rs1_en,
  input  logic        issue_rs2_en,
  input  logic [4:0]  issue_rs1_addr,
  input  logic [4:0]  issue_rs2_addr,
  input  logic        issue_rd_en,
  input  logic [4:0]  issue_rd_addr,
  input  logic        issue_long,
  input  logic        issue_div,
  input  logic        wb_valid,
  input  logic [4:0]  wb_addr,
  input  logic        flush,
  output logic        stall,
  output logic [1:0]  stall_reason,
  output logic [31:0] pending_vec,
  output logic        div_done,
  output logic [31:0] perf_raw_cycles,
  output logic [31:0] perf_div_cycles
);

  logic [31:0][1:0] cnt;
  logic [31:0]      inc_vec, dec_vec;
  logic             fire, div_busy, inc_en, dec_en;
  logic             rs1_pend, rs2_pend, waw_sat;
  sb_stall_t        reason;

  assign fire    = issue_valid && !stall && !flush;
  assign inc_en  = fire && issue_rd_en && issue_long && (issue_rd_addr != 5'd0);
  assign dec_en  = wb_valid && (wb_addr != 5'd0);
  assign inc_vec = inc_en ? (32'd1 << issue_rd_addr) : 32'd0;
  assign dec_vec = dec_en ? (32'd1 << wb_addr) : 32'd0;

  // r0 is only ever written by reset/flush, so it stays 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (flush) begin
      cnt <= '0;
    end else begin
      for (int i = 1; i < 32; i++) begin
        if (inc_vec[i] && !dec_vec[i] && cnt[i] != SB_CNT_MAX)
          cnt[i] <= cnt[i] + 2'd1;
        else if (dec_vec[i] && !inc_vec[i] && cnt[i] != 2'd0)
          cnt[i] <= cnt[i] - 2'd1;
      end
    end
  end

  underflow_chk: assert property (@(posedge clk) disable iff (!rst)
    !(dec_en && !flush && cnt[wb_addr] == 2'd0));

  always_comb begin
    pending_vec = '0;
    for (int i = 0; i < 32; i++) pending_vec[i] = (cnt[i] != 2'd0);
  end

  // A last outstanding write retiring this cycle is bypassed to the consumer.
  always_comb begin
    rs1_pend = issue_rs1_en && (issue_rs1_addr != 5'd0) && (cnt[issue_rs1_addr] != 2'd0) &&
               !(cnt[issue_rs1_addr] == 2'd1 && wb_valid && wb_addr == issue_rs1_addr);
    rs2_pend = issue_rs2_en && (issue_rs2_addr != 5'd0) && (cnt[issue_rs2_addr] != 2'd0) &&
               !(cnt[issue_rs2_addr] == 2'd1 && wb_valid && wb_addr == issue_rs2_addr);
    // A writeback to rd frees a slot in the same cycle, so the new write may enter.
    waw_sat  = issue_rd_en && issue_long && (cnt[issue_rd_addr] == SB_CNT_MAX) &&
               !(wb_valid && wb_addr == issue_rd_addr);
    reason = SB_NONE;
    if (issue_valid) begin
      if (issue_div && div_busy)    reason = SB_DIV_BUSY;
      else if (rs1_pend || rs2_pend) reason = SB_RAW;
      else if (waw_sat)             reason = SB_WAW_SAT;
    end
  end

  assign stall_reason = reason;
  assign stall        = (reason != SB_NONE);

  div_busy_fsm #(.DIV_LATENCY(DIV_LATENCY)) u_div_fsm (
    .clk   (clk),
    .rst   (rst),
    .start (fire && issue_div),
    .flush (flush),
    .busy  (div_busy),
    .done  (div_done)
  );

`ifdef SCOREBOARD_PERF_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_raw_cycles <= '0;
      perf_div_cycles <= '0;
    end else begin
      if (reason == SB_RAW)      perf_raw_cycles <= perf_raw_cycles + 32'd1;
      if (reason == SB_DIV_BUSY) perf_div_cycles <= perf_div_cycles + 32'd1;
    end
  end
`else
  assign perf_raw_cycles = '0;
  assign perf_div_cycles = '0;
`endif

endmodule

// File: tb/tb_issue_scoreboard.sv
`timescale 1ns/1ps
module tb_issue_scoreboard;

  localparam int DL = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        issue_valid, issue_rs1_en, issue_rs2_en;
  logic [4:0]  issue_rs1_addr, issue_rs2_addr;
  logic        issue_rd_en;
  logic [4:0]  issue_rd_addr;
  logic        issue_long, issue_div;
  logic        wb_valid;
  logic [4:0]  wb_addr;
  logic        flush;
  logic        stall;
  logic [1:0]  stall_reason;
  logic [31:0] pending_vec;
  logic        div_done;
  logic [31:0] perf_raw_cycles, perf_div_cycles;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int exp_q[$];   // expected div_done cycle numbers

  issue_scoreboard #(.DIV_LATENCY(DL)) dut (
    .clk            (clk),
    .rst            (rst),
    .issue_valid    (issue_valid),
    .issue_rs1_en   (issue_rs1_en),
    .issue_rs2_en   (issue_rs2_en),
    .issue_rs1_addr (issue_rs1_addr),
    .issue_rs2_addr (issue_rs2_addr),
    .issue_rd_en    (issue_rd_en),
    .issue_rd_addr  (issue_rd_addr),
    .issue_long     (issue_long),
    .issue_div      (issue_div),
    .wb_valid       (wb_valid),
    .wb_addr        (wb_addr),
    .flush          (flush),
    .stall          (stall),
    .stall_reason   (stall_reason),
    .pending_vec    (pending_vec),
    .div_done       (div_done),
    .perf_raw_cycles(perf_raw_cycles),
    .perf_div_cycles(perf_div_cycles)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // div_done scoreboard: every pulse must match the next expected cycle.
  always @(negedge clk) begin
    if (rst && div_done) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL div_done_unexpected: pulse at cycle %0d, none expected", cyc);
      end else begin
        int e;
        e = exp_q.pop_front();
        if (cyc !== e) begin
          bad++;
          $display("FAIL div_done_cycle: got cycle %0d expected %0d", cyc, e);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic set_idle();
    issue_valid = 0; issue_rs1_en = 0; issue_rs2_en = 0;
    issue_rs1_addr = 0; issue_rs2_addr = 0;
    issue_rd_en = 0; issue_rd_addr = 0; issue_long = 0; issue_div = 0;
    wb_valid = 0; wb_addr = 0; flush = 0;
  endtask

  task automatic next();
    @(posedge clk); #1;
    set_idle();
  endtask

  task automatic issue(input logic lng, input logic dv, input logic rd_en, input logic [4:0] rd,
                       input logic r1_en, input logic [4:0] r1, input logic r2_en, input logic [4:0] r2);
    issue_valid = 1; issue_long = lng; issue_div = dv;
    issue_rd_en = rd_en; issue_rd_addr = rd;
    issue_rs1_en = r1_en; issue_rs1_addr = r1;
    issue_rs2_en = r2_en; issue_rs2_addr = r2;
  endtask

  task automatic wb(input logic [4:0] a);
    wb_valid = 1; wb_addr = a;
  endtask

  task automatic do_reset();
    set_idle();
    @(negedge clk); rst = 0;
    exp_q.delete();
    @(negedge clk); rst = 1;
  endtask

  task automatic wait_div_drain();
    for (int k = 0; k < 4 * DL && exp_q.size() != 0; k++) begin
      next();
      @(negedge clk); #1;
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL div_drain_timeout: %0d pulses outstanding, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    set_idle();
    rst = 0;
    #2;
    issue(0, 0, 0, 0, 1, 5'd5, 0, 0);
    #1;
    total++;
    if (stall !== 1'b0 || stall_reason !== 2'd0 || pending_vec !== 32'd0 || div_done !== 1'b0) begin
      bad++;
      $display("FAIL reset_outputs: stall=%0b reason=%0d pend=%h done=%0b, expected all 0",
               stall, stall_reason, pending_vec, div_done);
    end
    total++;
    if (perf_raw_cycles !== 32'd0 || perf_div_cycles !== 32'd0) begin
      bad++;
      $display("FAIL reset_perf: raw=%0d div=%0d expected 0 0", perf_raw_cycles, perf_div_cycles);
    end
    set_idle();
    @(negedge clk); rst = 1;
  endtask

  task automatic test_load_use();
    do_reset();
    next(); issue(1, 0, 1, 5'd5, 0, 0, 0, 0); @(negedge clk);
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL lu_load_fire: stall=%0b expected 0", stall); end
    next(); issue(0, 0, 1, 5'd1, 1, 5'd5, 0, 0); issue_valid = 0; @(negedge clk);
    total++; if (stall !== 1'b0 || stall_reason !== 2'd0) begin bad++; $display("FAIL lu_invalid_mask: stall=%0b reason=%0d expected 0 0", stall, stall_reason); end
    next(); issue(0, 0, 1, 5'd1, 1, 5'd5, 0, 0); @(negedge clk);
    total++; if (stall !== 1'b1 || stall_reason !== 2'd1 || pending_vec[5] !== 1'b1) begin bad++; $display("FAIL lu_raw: stall=%0b reason=%0d pend5=%0b expected 1 1 1", stall, stall_reason, pending_vec[5]); end
    next(); issue(0, 0, 1, 5'd1, 1, 5'd5, 0, 0); wb(5'd5); @(negedge clk);
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL lu_bypass: stall=%0b expected 0", stall); end
    next(); @(negedge clk);
    total++; if (pending_vec !== 32'd0) begin bad++; $display("FAIL lu_cleared: pend=%h expected 0", pending_vec); end
    // two outstanding writes: one writeback is not enough
    next(); issue(1, 0, 1, 5'd6, 0, 0, 0, 0); @(negedge clk);
    next(); issue(1, 0, 1, 5'd6, 0, 0, 0, 0); @(negedge clk);
    next(); issue(0, 0, 0, 0, 0, 0, 1, 5'd6); wb(5'd6); @(negedge clk);
    total++; if (stall !== 1'b1 || stall_reason !== 2'd1) begin bad++; $display("FAIL lu_cnt2_rs2: stall=%0b reason=%0d expected 1 1", stall, stall_reason); end
    next(); issue(0, 0, 0, 0, 0, 0, 1, 5'd6); wb(5'd6); @(negedge clk);
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL lu_cnt1_rs2: stall=%0b expected 0", stall); end
    next(); @(negedge clk);
    total++; if (pending_vec !== 32'd0) begin bad++; $display("FAIL lu_r6_cleared: pend=%h expected 0", pending_vec); end
  endtask

  task automatic test_waw_sat();
    logic exp_st [3] = '{1'b1, 1'b1, 1'b0};
    do_reset();
    for (int k = 0; k < 3; k++) begin
      next(); issue(1, 0, 1, 5'd7, 0, 0, 0, 0); @(negedge clk);
      total++; if (stall !== 1'b0) begin bad++; $display("FAIL waw_fill%0d: stall=%0b expected 0", k, stall); end
    end
    next(); issue(1, 0, 1, 5'd7, 0, 0, 0, 0); @(negedge clk);
    total++; if (stall !== 1'b1 || stall_reason !== 2'd2 || pending_vec !== 32'h80) begin bad++; $display("FAIL waw_sat: stall=%0b reason=%0d pend=%h expected 1 2 00000080", stall, stall_reason, pending_vec); end
    next(); issue(1, 0, 1, 5'd7, 0, 0, 0, 0); wb(5'd7); @(negedge clk);
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL waw_wb_fire: stall=%0b expected 0", stall); end
    next(); issue(1, 0, 1, 5'd7, 0, 0, 0, 0); @(negedge clk);
    total++; if (stall_reason !== 2'd2) begin bad++; $display("FAIL waw_still3: reason=%0d expected 2", stall_reason); end
    next(); issue(0, 0, 1, 5'd7, 0, 0, 0, 0); @(negedge clk);
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL waw_short_write: stall=%0b expected 0", stall); end
    for (int k = 0; k < 3; k++) begin
      next(); issue(0, 0, 0, 0, 0, 0, 1, 5'd7); wb(5'd7); @(negedge clk);
      total++; if (stall !== exp_st[k]) begin bad++; $display("FAIL waw_drain%0d: stall=%0b expected %0b", k, stall, exp_st[k]); end
    end
    next(); @(negedge clk);
    total++; if (pending_vec !== 32'd0) begin bad++; $display("FAIL waw_empty: pend=%h expected 0", pending_vec); end
  endtask

  task automatic test_div();
    do_reset();
    next(); issue(0, 1, 0, 0, 0, 0, 0, 0); @(negedge clk);
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL div_first_fire: stall=%0b expected 0", stall); end
    exp_q.push_back(cyc + DL);
    for (int k = 1; k < DL; k++) begin
      next(); issue(0, 1, 0, 0, 0, 0, 0, 0); @(negedge clk);
      total++; if (stall !== 1'b1 || stall_reason !== 2'd3 || div_done !== 1'b0) begin bad++; $display("FAIL div_busy%0d: stall=%0b reason=%0d done=%0b expected 1 3 0", k, stall, stall_reason, div_done); end
    end
    next(); issue(0, 1, 0, 0, 0, 0, 0, 0); @(negedge clk);
    total++; if (div_done !== 1'b1 || stall !== 1'b0) begin bad++; $display("FAIL div_b2b: done=%0b stall=%0b expected 1 0", div_done, stall); end
    exp_q.push_back(cyc + DL);
    next(); issue(1, 0, 1, 5'd12, 0, 0, 0, 0); @(negedge clk);
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL div_nondiv_ok: stall=%0b expected 0", stall); end
    next(); issue(0, 1, 0, 0, 1, 5'd12, 0, 0); @(negedge clk);
    total++; if (stall_reason !== 2'd3) begin bad++; $display("FAIL div_prio: reason=%0d expected 3", stall_reason); end
    next(); wb(5'd12); @(negedge clk);
    wait_div_drain();
  endtask

  task automatic test_flush();
    do_reset();
    next(); issue(1, 0, 1, 5'd3, 0, 0, 0, 0); @(negedge clk);
    next(); issue(1, 0, 1, 5'd9, 0, 0, 0, 0); @(negedge clk);
    next(); @(negedge clk);
    total++; if (pending_vec !== 32'h208) begin bad++; $display("FAIL fl_pending: pend=%h expected 00000208", pending_vec); end
    next(); flush = 1; issue(1, 0, 1, 5'd4, 0, 0, 0, 0); wb(5'd3); @(negedge clk);
    next(); issue(0, 0, 1, 5'd1, 1, 5'd3, 1, 5'd9); @(negedge clk);
    total++; if (stall !== 1'b0 || pending_vec !== 32'd0) begin bad++; $display("FAIL fl_cleared: stall=%0b pend=%h expected 0 0", stall, pending_vec); end
    next(); issue(0, 1, 0, 0, 0, 0, 0, 0); @(negedge clk);
    next(); flush = 1; @(negedge clk);
    next(); issue(0, 1, 0, 0, 0, 0, 0, 0); @(negedge clk);
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL fl_div_idle: stall=%0b expected 0", stall); end
    exp_q.push_back(cyc + DL);
    wait_div_drain();
  endtask

  task automatic test_r0();
    do_reset();
    next(); issue(1, 0, 1, 5'd0, 0, 0, 0, 0); @(negedge clk);
    next(); issue(0, 0, 1, 5'd2, 1, 5'd0, 1, 5'd0); @(negedge clk);
    total++; if (stall !== 1'b0 || pending_vec !== 32'd0) begin bad++; $display("FAIL r0_consumer: stall=%0b pend=%h expected 0 0", stall, pending_vec); end
    next(); wb(5'd0); @(negedge clk);
    total++; if (pending_vec !== 32'd0) begin bad++; $display("FAIL r0_wb: pend=%h expected 0", pending_vec); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    next(); issue(1, 0, 1, 5'd5, 0, 0, 0, 0); @(negedge clk);
    next(); issue(0, 1, 0, 0, 0, 0, 0, 0); @(negedge clk);
    next(); #2;
    rst = 0;
    exp_q.delete();
    #1;
    total++; if (pending_vec !== 32'd0 || div_done !== 1'b0) begin bad++; $display("FAIL rm_async: pend=%h done=%0b expected 0 0", pending_vec, div_done); end
    @(negedge clk); rst = 1;
    next(); issue(0, 1, 0, 0, 1, 5'd5, 0, 0); @(negedge clk);
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL rm_first_edge: stall=%0b expected 0", stall); end
    exp_q.push_back(cyc + DL);
    wait_div_drain();
  endtask

  task automatic test_perf();
    int exp_raw, exp_div;
`ifdef SCOREBOARD_PERF_EN
    exp_raw = 5; exp_div = 7;
`else
    exp_raw = 0; exp_div = 0;
`endif
    do_reset();
    next(); issue(1, 0, 1, 5'd5, 0, 0, 0, 0); @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      next(); issue(0, 0, 0, 0, 1, 5'd5, 0, 0); @(negedge clk);
    end
    next(); issue(0, 0, 0, 0, 1, 5'd5, 0, 0); wb(5'd5); @(negedge clk);
    next(); issue(0, 1, 0, 0, 0, 0, 0, 0); @(negedge clk);
    exp_q.push_back(cyc + DL);
    for (int k = 1; k < DL; k++) begin
      next(); issue(0, 1, 0, 0, 0, 0, 0, 0); @(negedge clk);
    end
    next(); issue(0, 1, 0, 0, 0, 0, 0, 0); @(negedge clk);
    exp_q.push_back(cyc + DL);
    wait_div_drain();
    total++; if (perf_raw_cycles !== 32'(exp_raw) || perf_div_cycles !== 32'(exp_div)) begin bad++; $display("FAIL perf_counts: raw=%0d div=%0d expected %0d %0d", perf_raw_cycles, perf_div_cycles, exp_raw, exp_div); end
    #2; rst = 0; #1;
    total++; if (perf_raw_cycles !== 32'd0 || perf_div_cycles !== 32'd0) begin bad++; $display("FAIL perf_reset: raw=%0d div=%0d expected 0 0", perf_raw_cycles, perf_div_cycles); end
    @(negedge clk); rst = 1;
  endtask

  initial begin
    set_idle();
    test_reset();
    test_load_use();
    test_waw_sat();
    test_div();
    test_flush();
    test_r0();
    test_reset_mid();
    test_perf();
    next(); @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
